fifo_to_axi: RTL and testbench

//  Read side of the RLDRAM packet path: drains 278-bit words from the memory-side async FIFO
//  and re-emits them as an AXI4-Stream master. Rebuilds tstrb from the stored byte count and

---
 rtl/rldram_pkg.sv | 31 +++
 rtl/axis_skid_buf.sv | 62 ++++++
 rtl/fifo_to_axi.sv | 137 +++++++++++++
 tb/tb_fifo_to_axi.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rldram_pkg.sv
// Shared constants for the RLDRAM packet path.
// Covers the FIFO word layout, the read-side FSM states and the byte-strobe decode.
package rldram_pkg;

  localparam int BEAT_BYTES = 32;
  localparam int WORD_WIDTH = 8 * BEAT_BYTES + 6 + 16;

  // FIFO word layout: {len[15:0], tdata[255:0], cnt[4:0], last}
  localparam int LEN_MSB  = 277;
  localparam int LEN_LSB  = 262;
  localparam int DATA_LSB = 6;
  localparam int DATA_MSB = LEN_LSB - 1;
  localparam int CNT_LSB  = 1;
  localparam int CNT_MSB  = DATA_LSB - 1;
  localparam int LAST_BIT = 0;

  typedef enum logic [0:0] {
    SOP = 1'b0,
    MID = 1'b1
  } fsm_state_t;

  // cnt holds bytes-1, so the shift needs one bit more than the strobe width.
  function automatic logic [BEAT_BYTES-1:0] cnt_to_strb(input logic [4:0] cnt);
    logic [BEAT_BYTES:0] one;
    logic [BEAT_BYTES:0] ones;
    one  = {{BEAT_BYTES{1'b0}}, 1'b1};
    ones = (one << ({1'b0, cnt} + 6'd1)) - one;
    return ones[BEAT_BYTES-1:0];
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry first-word-fall-through buffer that absorbs the one-cycle FIFO read latency.
// The head entry is always entry0; occupancy tells the reader how much room is left.
module axis_skid_buf #(
  parameter int WIDTH = 278
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] entry0_reg;
  logic [WIDTH-1:0] entry1_reg;
  logic [1:0]       occ_reg;
  logic             pop_ok;

  assign pop_ok = pop && (occ_reg != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_reg <= '0;
      entry1_reg <= '0;
      occ_reg    <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            entry0_reg <= push_data;
            occ_reg    <= 2'd1;
          end else if (occ_reg == 2'd1) begin
            entry1_reg <= push_data;
            occ_reg    <= 2'd2;
          end
        end
        2'b01: begin
          entry0_reg <= entry1_reg;
          occ_reg    <= occ_reg - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and refill keeps occupancy unchanged.
          if (occ_reg == 2'd1) begin
            entry0_reg <= push_data;
          end else begin
            entry0_reg <= entry1_reg;
            entry1_reg <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_data  = entry0_reg;
  assign head_valid = (occ_reg != 2'd0);
  assign occupancy  = occ_reg;

endmodule

// File: rtl/fifo_to_axi.sv
// Drains RLDRAM read-side FIFO words and replays them as an AXI4-Stream master,
// rebuilding tstrb/tuser and returning one output_inc credit per delivered beat.
module fifo_to_axi
  import rldram_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 128,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4,
  parameter int WORD_WIDTH  = 278
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_WIDTH-1:0]    fifo_dout,
  input  logic                     fifo_empty,
  input  logic                     fifo_dvalid,
  output logic                     rinc,
  output logic                     tvalid,
  input  logic                     tready,
  output logic [8*TDATA_WIDTH-1:0] tdata,
  output logic [TDATA_WIDTH-1:0]   tstrb,
  output logic                     tlast,
  output logic [TUSER_WIDTH-1:0]   tuser,
  output logic [TID_WIDTH-1:0]     tid,
  output logic [TDEST_WIDTH-1:0]   tdest,
  output logic                     output_inc,
  output logic [31:0]              pkt_cnt,
  output logic                     len_err
);

  logic [WORD_WIDTH-1:0] head;
  logic                  head_valid;
  logic [1:0]            occupancy;
  logic                  accept;
  logic                  inflight_reg;
  logic [2:0]            slots_used;

  fsm_state_t state_reg;
  fsm_state_t state_next;
  logic [15:0] len_reg;
  logic [16:0] beats_reg;
  logic [31:0] pkt_cnt_reg;
  logic        len_err_reg;
  logic        output_inc_reg;

  logic [15:0] head_len;
  logic [4:0]  head_cnt;
  logic        head_last;
  logic [15:0] pkt_len;
  logic [16:0] pkt_beats;
  logic [16:0] exp_beats;

  axis_skid_buf #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_dvalid),
    .push_data (fifo_dout),
    .pop       (accept),
    .head_data (head),
    .head_valid(head_valid),
    .occupancy (occupancy)
  );

  assign accept = head_valid & tready;

  // Occupancy is taken after this cycle's pop so a drained slot can be refilled at
  // once; inflight equals this cycle's dvalid because read latency is exactly one.
  assign slots_used = {1'b0, occupancy} + {2'b0, inflight_reg} - {2'b0, accept};
  assign rinc       = !fifo_empty && (slots_used < 3'd2);

  assign head_len  = head[LEN_MSB:LEN_LSB];
  assign head_cnt  = head[CNT_MSB:CNT_LSB];
  assign head_last = head[LAST_BIT];

  // The head beat of a packet carries its own len, so tuser is valid before it is latched.
  assign pkt_len   = (state_reg == SOP) ? head_len : len_reg;
  assign pkt_beats = (state_reg == SOP) ? 17'd1 : beats_reg + 17'd1;
  assign exp_beats = ({1'b0, pkt_len} + 17'd31) >> 5;

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = head_last ? SOP : MID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg   <= 1'b0;
      state_reg      <= SOP;
      len_reg        <= 16'd0;
      beats_reg      <= 17'd0;
      pkt_cnt_reg    <= 32'd0;
      len_err_reg    <= 1'b0;
      output_inc_reg <= 1'b0;
    end else begin
      inflight_reg   <= rinc;
      state_reg      <= state_next;
      output_inc_reg <= accept;
      if (accept) begin
        beats_reg <= pkt_beats;
        if (state_reg == SOP) begin
          len_reg <= head_len;
        end
        if (head_last) begin
          pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
          if (pkt_beats != exp_beats) begin
            len_err_reg <= 1'b1;
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_dvalid && occupancy == 2'd2))
        else $error("fifo_to_axi: FIFO data arrived with skid buffer full");
    end
  end
`endif

  assign tvalid     = head_valid;
  assign tdata      = head[DATA_MSB:DATA_LSB];
  assign tstrb      = head_valid ? cnt_to_strb(head_cnt) : '0;
  assign tlast      = head_valid & head_last;
  assign tuser      = head_valid ? {{(TUSER_WIDTH-16){1'b0}}, pkt_len} : '0;
  assign tid        = '0;
  assign tdest      = '0;
  assign output_inc = output_inc_reg;
  assign pkt_cnt    = pkt_cnt_reg;
  assign len_err    = len_err_reg;

endmodule

// File: tb/tb_fifo_to_axi.sv
// Directed bench for fifo_to_axi: a behavioural 1-cycle-latency FIFO feeds the DUT
// and a negedge monitor records every accepted AXIS beat for in-order checking.
module tb_fifo_to_axi;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [277:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_dvalid;
  logic         rinc;
  logic         tvalid;
  logic         tready = 1'b0;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic         tlast;
  logic [127:0] tuser;
  logic [3:0]   tid;
  logic [3:0]   tdest;
  logic         output_inc;
  logic [31:0]  pkt_cnt;
  logic         len_err;

  logic         wr_en = 1'b0;
  logic [277:0] wr_data = '0;
  logic [277:0] fq[$];
  int           underflow = 0;

  beat_t        mon_q[$];
  int           inc_total = 0;
  int           stab_err = 0;
  logic         prev_stall = 1'b0;
  beat_t        prev_beat;

  logic [277:0] tx_q[$];
  beat_t        exp_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  always #5 clk = ~clk;

  fifo_to_axi dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_dvalid(fifo_dvalid),
    .rinc       (rinc),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tstrb      (tstrb),
    .tlast      (tlast),
    .tuser      (tuser),
    .tid        (tid),
    .tdest      (tdest),
    .output_inc (output_inc),
    .pkt_cnt    (pkt_cnt),
    .len_err    (len_err)
  );

  // Memory-side FIFO: data appears one cycle after rinc; flushed together with the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      fifo_dvalid <= 1'b0;
      fifo_dout   <= '0;
      fifo_empty  <= 1'b1;
    end else begin
      if (rinc) begin
        if (fq.size() == 0) begin
          underflow   <= underflow + 1;
          fifo_dvalid <= 1'b0;
        end else begin
          fifo_dout   <= fq.pop_front();
          fifo_dvalid <= 1'b1;
        end
      end else begin
        fifo_dvalid <= 1'b0;
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (output_inc === 1'b1) inc_total <= inc_total + 1;
    if (prev_stall && !reset &&
        (tvalid !== 1'b1 || {tdata, tstrb, tlast, tuser} !== prev_beat)) begin
      stab_err <= stab_err + 1;
    end
    if (tvalid === 1'b1 && tready === 1'b1) mon_q.push_back({tdata, tstrb, tlast, tuser});
    prev_stall <= (tvalid === 1'b1) && (tready === 1'b0) && !reset;
    prev_beat  <= {tdata, tstrb, tlast, tuser};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input int len, input logic [255:0] d, input int cnt, input bit last);
    logic [15:0] l16;
    logic [4:0]  c5;
    logic [32:0] s;
    l16 = len[15:0];
    c5  = cnt[4:0];
    s   = (33'd1 << (cnt + 1)) - 33'd1;
    tx_q.push_back({l16, d, c5, last});
    exp_q.push_back({d, s[31:0], last, {112'd0, l16}});
  endtask

  task automatic run_traffic(input bit rand_ready, input int n_beats, input int budget,
                             output bit timed_out, output int max_run);
    int base;
    int idx;
    int run;
    int cyc;
    base = mon_q.size();
    idx = 0; run = 0; max_run = 0; cyc = 0; timed_out = 1'b0;
    while (mon_q.size() < base + n_beats) begin
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      wr_en = (idx < tx_q.size());
      if (wr_en) begin
        wr_data = tx_q[idx];
        idx++;
      end
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (tvalid === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tready = 1'b0; wr_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total_cnt++;
      if (rinc !== 1'b0 || tvalid !== 1'b0)
        $display("FAIL reset_idle cycle %0d: rinc=%b tvalid=%b, required 0/0", i, rinc, tvalid);
      else pass_cnt++;
    end
    total_cnt++;
    if (tdata !== 256'd0) $display("FAIL reset_tdata: got %h required 0", tdata); else pass_cnt++;
    total_cnt++;
    if (tstrb !== 32'd0) $display("FAIL reset_tstrb: got %h required 0", tstrb); else pass_cnt++;
    total_cnt++;
    if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b required 0", tlast); else pass_cnt++;
    total_cnt++;
    if (tuser !== 128'd0) $display("FAIL reset_tuser: got %h required 0", tuser); else pass_cnt++;
    total_cnt++;
    if (output_inc !== 1'b0) $display("FAIL reset_output_inc: got %b required 0", output_inc); else pass_cnt++;
    total_cnt++;
    if (pkt_cnt !== 32'd0) $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt); else pass_cnt++;
    total_cnt++;
    if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b required 0", len_err); else pass_cnt++;
    total_cnt++;
    if (tid !== 4'd0 || tdest !== 4'd0) $display("FAIL reset_tid_tdest: got %h/%h required 0/0", tid, tdest); else pass_cnt++;
    $display("test_reset done: pkt_cnt=%0d", pkt_cnt);
  endtask

  task automatic test_single_64();
    logic [255:0] d[2];
    logic [31:0]  xs[2];
    logic         xl[2];
    bit to;
    int mr, base, inc_base;
    d[0] = {8{32'h0A0B_0C00}}; d[1] = {8{32'h1122_3344}};
    xs[0] = 32'hFFFF_FFFF; xs[1] = 32'hFFFF_FFFF;
    xl[0] = 1'b0; xl[1] = 1'b1;
    tx_q.delete(); exp_q.delete();
    base = mon_q.size(); inc_base = inc_total;
    add_beat(64, d[0], 31, 1'b0);
    add_beat(64, d[1], 31, 1'b1);
    run_traffic(1'b0, 2, 50, to, mr);
    total_cnt++;
    if (to) $display("FAIL pkt64_timeout: got %0d beats required 2", mon_q.size() - base); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (base + i < mon_q.size()) begin
        total_cnt++;
        if (mon_q[base+i].data !== d[i] || mon_q[base+i].strb !== xs[i] ||
            mon_q[base+i].last !== xl[i] || mon_q[base+i].user !== 128'd64)
          $display("FAIL pkt64_beat%0d: got strb=%h last=%b user=%0d required strb=%h last=%b user=64",
                   i, mon_q[base+i].strb, mon_q[base+i].last, mon_q[base+i].user, xs[i], xl[i]);
        else pass_cnt++;
        $display("pkt64 beat %0d: strb=%h last=%b user=%0d", i, mon_q[base+i].strb,
                 mon_q[base+i].last, mon_q[base+i].user);
      end
    end
    repeat (3) tick();
    total_cnt++;
    if (inc_total - inc_base !== 2) $display("FAIL pkt64_output_inc: got %0d required 2", inc_total - inc_base); else pass_cnt++;
    total_cnt++;
    if (pkt_cnt !== 32'd1) $display("FAIL pkt64_pkt_cnt: got %0d required 1", pkt_cnt); else pass_cnt++;
    total_cnt++;
    if (len_err !== 1'b0) $display("FAIL pkt64_len_err: got %b required 0", len_err); else pass_cnt++;
  endtask

  task automatic test_pkt_65();
    logic [255:0] d[3];
    logic [31:0]  xs[3];
    logic         xl[3];
    bit to;
    int mr, base;
    d[0] = {8{32'hDEAD_0001}}; d[1] = {8{32'hDEAD_0002}}; d[2] = {8{32'hDEAD_0003}};
    xs[0] = 32'hFFFF_FFFF; xs[1] = 32'hFFFF_FFFF; xs[2] = 32'h0000_0001;
    xl[0] = 1'b0; xl[1] = 1'b0; xl[2] = 1'b1;
    tx_q.delete(); exp_q.delete();
    base = mon_q.size();
    add_beat(65, d[0], 31, 1'b0);
    add_beat(65, d[1], 31, 1'b0);
    add_beat(65, d[2], 0, 1'b1);
    run_traffic(1'b0, 3, 50, to, mr);
    total_cnt++;
    if (to) $display("FAIL pkt65_timeout: got %0d beats required 3", mon_q.size() - base); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (base + i < mon_q.size()) begin
        total_cnt++;
        if (mon_q[base+i].data !== d[i] || mon_q[base+i].strb !== xs[i] ||
            mon_q[base+i].last !== xl[i] || mon_q[base+i].user !== 128'd65)
          $display("FAIL pkt65_beat%0d: got strb=%h last=%b user=%0d required strb=%h last=%b user=65",
                   i, mon_q[base+i].strb, mon_q[base+i].last, mon_q[base+i].user, xs[i], xl[i]);
        else pass_cnt++;
        $display("pkt65 beat %0d: strb=%h last=%b user=%0d", i, mon_q[base+i].strb,
                 mon_q[base+i].last, mon_q[base+i].user);
      end
    end
    repeat (3) tick();
    total_cnt++;
    if (pkt_cnt !== 32'd2 || len_err !== 1'b0)
      $display("FAIL pkt65_status: got pkt_cnt=%0d len_err=%b required 2/0", pkt_cnt, len_err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit to;
    int mr, base, errs;
    tx_q.delete(); exp_q.delete();
    base = mon_q.size(); errs = 0;
    for (int i = 0; i < 10; i++) add_beat(3 * i + 1, {8{$urandom()}}, 3 * i, 1'b1);
    run_traffic(1'b0, 10, 60, to, mr);
    repeat (3) tick();
    total_cnt++;
    if (to) $display("FAIL b2b_timeout: got %0d beats required 10", mon_q.size() - base); else pass_cnt++;
    total_cnt++;
    if (mr !== 10) $display("FAIL b2b_consecutive_tvalid: got %0d required 10", mr); else pass_cnt++;
    for (int i = 0; i < 10 && base + i < mon_q.size(); i++) begin
      if (mon_q[base+i] !== exp_q[i]) begin
        errs++;
        $display("FAIL b2b_beat%0d: got strb=%h user=%0d required strb=%h user=%0d", i,
                 mon_q[base+i].strb, mon_q[base+i].user, exp_q[i].strb, exp_q[i].user);
      end
    end
    total_cnt++;
    if (errs != 0) $display("FAIL b2b_data: got %0d bad beats required 0", errs); else pass_cnt++;
    total_cnt++;
    if (pkt_cnt !== 32'd12 || underflow != 0)
      $display("FAIL b2b_status: got pkt_cnt=%0d underflow=%0d required 12/0", pkt_cnt, underflow);
    else pass_cnt++;
    $display("b2b: %0d beats, longest tvalid run %0d", mon_q.size() - base, mr);
  endtask

  task automatic test_random_ready();
    bit to;
    int mr, base, inc_base, errs, nbeats, len, nb;
    tx_q.delete(); exp_q.delete();
    base = mon_q.size(); inc_base = inc_total; errs = 0;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 100);
      nb = (len + 31) / 32;
      for (int b = 0; b < nb; b++)
        add_beat(len, {8{$urandom()}}, (b == nb - 1) ? (len - 1) % 32 : 31, b == nb - 1);
    end
    nbeats = exp_q.size();
    run_traffic(1'b1, nbeats, 5000, to, mr);
    tready = 1'b1;
    repeat (5) tick();
    total_cnt++;
    if (to) $display("FAIL rand_timeout: got %0d beats required %0d", mon_q.size() - base, nbeats); else pass_cnt++;
    total_cnt++;
    if (mon_q.size() - base != nbeats)
      $display("FAIL rand_beat_count: got %0d required %0d", mon_q.size() - base, nbeats);
    else pass_cnt++;
    for (int i = 0; i < nbeats && base + i < mon_q.size(); i++) begin
      if (mon_q[base+i] !== exp_q[i]) begin
        errs++;
        if (errs <= 4)
          $display("FAIL rand_beat%0d: got strb=%h last=%b user=%0d required strb=%h last=%b user=%0d",
                   i, mon_q[base+i].strb, mon_q[base+i].last, mon_q[base+i].user,
                   exp_q[i].strb, exp_q[i].last, exp_q[i].user);
      end
    end
    total_cnt++;
    if (errs != 0) $display("FAIL rand_data: got %0d bad beats required 0", errs); else pass_cnt++;
    total_cnt++;
    if (inc_total - inc_base != nbeats)
      $display("FAIL rand_output_inc: got %0d required %0d", inc_total - inc_base, nbeats);
    else pass_cnt++;
    total_cnt++;
    if (stab_err != 0) $display("FAIL rand_stability: got %0d violations required 0", stab_err); else pass_cnt++;
    total_cnt++;
    if (pkt_cnt !== 32'd112 || len_err !== 1'b0)
      $display("FAIL rand_status: got pkt_cnt=%0d len_err=%b required 112/0", pkt_cnt, len_err);
    else pass_cnt++;
    $display("rand: %0d beats over 100 packets, %0d credits", nbeats, inc_total - inc_base);
  endtask

  task automatic test_len_err_and_reset();
    logic [255:0] d0, d1;
    bit to;
    int mr, base;
    tx_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) add_beat(64, {8{32'hBAD0_0000 + i}}, 31, i == 2);
    run_traffic(1'b0, 3, 50, to, mr);
    repeat (2) tick();
    total_cnt++;
    if (to || len_err !== 1'b1 || pkt_cnt !== 32'd113)
      $display("FAIL lenerr_set: got timeout=%b len_err=%b pkt_cnt=%0d required 0/1/113", to, len_err, pkt_cnt);
    else pass_cnt++;

    tx_q.delete(); exp_q.delete();
    add_beat(64, {8{32'h5555_AAAA}}, 31, 1'b0);
    run_traffic(1'b0, 1, 50, to, mr);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (len_err !== 1'b0 || tvalid !== 1'b0 || pkt_cnt !== 32'd0 || tuser !== 128'd0)
      $display("FAIL midreset: got len_err=%b tvalid=%b pkt_cnt=%0d tuser=%0d required 0/0/0/0",
               len_err, tvalid, pkt_cnt, tuser);
    else pass_cnt++;

    d0 = {8{32'hC0DE_0040}}; d1 = {8{32'hC0DE_0041}};
    tx_q.delete(); exp_q.delete();
    base = mon_q.size();
    add_beat(40, d0, 31, 1'b0);
    add_beat(40, d1, 7, 1'b1);
    run_traffic(1'b0, 2, 50, to, mr);
    repeat (2) tick();
    total_cnt++;
    if (to) $display("FAIL after_reset_timeout: got %0d beats required 2", mon_q.size() - base); else pass_cnt++;
    if (!to) begin
      total_cnt++;
      if (mon_q[base].data !== d0 || mon_q[base].strb !== 32'hFFFF_FFFF ||
          mon_q[base].last !== 1'b0 || mon_q[base].user !== 128'd40)
        $display("FAIL after_reset_beat0: got strb=%h last=%b user=%0d required FFFFFFFF/0/40",
                 mon_q[base].strb, mon_q[base].last, mon_q[base].user);
      else pass_cnt++;
      total_cnt++;
      if (mon_q[base+1].data !== d1 || mon_q[base+1].strb !== 32'h0000_00FF ||
          mon_q[base+1].last !== 1'b1 || mon_q[base+1].user !== 128'd40)
        $display("FAIL after_reset_beat1: got strb=%h last=%b user=%0d required 000000FF/1/40",
                 mon_q[base+1].strb, mon_q[base+1].last, mon_q[base+1].user);
      else pass_cnt++;
    end
    total_cnt++;
    if (pkt_cnt !== 32'd1 || len_err !== 1'b0)
      $display("FAIL after_reset_status: got pkt_cnt=%0d len_err=%b required 1/0", pkt_cnt, len_err);
    else pass_cnt++;
    $display("len_err/reset: post-reset packet pkt_cnt=%0d len_err=%b", pkt_cnt, len_err);
  endtask

  initial begin
    test_reset();
    test_single_64();
    test_pkt_65();
    test_back_to_back();
    test_random_ready();
    test_len_err_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
